// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams and TX FIFO write port of the UART transmit arbiter.
// The arbiter uses the slave modport; the requesters together with the FIFO use master.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int BIT   = 8
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*BIT-1:0] req_data;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ-1:0]     req_ready;
    logic                 fifo_full;
    logic                 fifo_wr_en;
    logic [BIT-1:0]       fifo_data;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART TX FIFO write port among N_REQ
// requesters. A grant is released on the last byte, at the burst cap or after an idle timeout.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int BIT       = 8,
    parameter int MAX_BURST = 16,
    parameter int IDLE_TO   = 32,
    localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_tx_arbiter_if.slave    bus,
    output logic                busy,
    output logic [GW-1:0]       grant_id,
    output logic                rel_timeout,
    output logic                rel_burst
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [7:0]     burst_q, burst_d;
    logic [7:0]     idle_q, idle_d;
    logic           rel_to_q, rel_to_d;
    logic           rel_burst_q, rel_burst_d;

    logic           sel_valid_s;
    logic           sel_last_s;
    logic [BIT-1:0] sel_data_s;
    logic           xfer_s;
    logic [GW:0]    pick_s;
    logic [8:0]     burst_inc_s;
    logic [8:0]     idle_inc_s;
    logic [N_REQ-1:0] ready_s;
    logic           wr_en_s;
    logic [BIT-1:0] wr_data_s;

    // First valid requester after 'last' with wrap-around; MSB flags that one was found.
    function automatic logic [GW:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [GW-1:0]    last);
        logic          found;
        logic [GW-1:0] pick;
        int            idx;
        found = 1'b0;
        pick  = last;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last) + i) % N_REQ;
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
        return {found, pick};
    endfunction

    // Selected requester's lane and the transfer qualifier.
    always_comb begin
        sel_valid_s = bus.req_valid[grant_q];
        sel_last_s  = bus.req_last[grant_q];
        sel_data_s  = bus.req_data[int'(grant_q)*BIT +: BIT];
        xfer_s      = (state_q == ST_LOCKED) && sel_valid_s && !bus.fifo_full;
        pick_s      = rr_pick(bus.req_valid, grant_q);
        burst_inc_s = {1'b0, burst_q} + 9'd1;
        idle_inc_s  = {1'b0, idle_q} + 9'd1;
    end

    // Next-state, counters and release pulses.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        burst_d     = burst_q;
        idle_d      = idle_q;
        rel_to_d    = 1'b0;
        rel_burst_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[GW]) begin
                    grant_d = pick_s[GW-1:0];
                    state_d = ST_LOCKED;
                    burst_d = 8'd0;
                    idle_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s) begin
                    burst_d = burst_inc_s[7:0];
                    idle_d  = 8'd0;
                    // A message end on the capped byte is an ordinary release, not a burst release.
                    if (sel_last_s) begin
                        state_d = ST_IDLE;
                    end else if (burst_inc_s == 9'(MAX_BURST)) begin
                        state_d     = ST_IDLE;
                        rel_burst_d = 1'b1;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else if (!sel_valid_s) begin
                    idle_d = idle_inc_s[7:0];
                    if (idle_inc_s == 9'(IDLE_TO)) begin
                        state_d  = ST_IDLE;
                        rel_to_d = 1'b1;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    // Valid but FIFO full: stalled, no counter moves, so no timeout.
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO handshake decoded from the registered grant only.
    always_comb begin
        ready_s   = '0;
        wr_en_s   = 1'b0;
        wr_data_s = '0;
        if (state_q == ST_LOCKED) begin
            ready_s[grant_q] = !bus.fifo_full;
            wr_en_s          = xfer_s;
            wr_data_s        = xfer_s ? sel_data_s : '0;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // State register; grant_q doubles as the last-grant pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= GW'(N_REQ - 1);
            burst_q     <= 8'd0;
            idle_q      <= 8'd0;
            rel_to_q    <= 1'b0;
            rel_burst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            burst_q     <= burst_d;
            idle_q      <= idle_d;
            rel_to_q    <= rel_to_d;
            rel_burst_q <= rel_burst_d;
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.fifo_wr_en = wr_en_s;
    assign bus.fifo_data  = wr_data_s;
    assign busy           = (state_q == ST_LOCKED);
    assign grant_id       = grant_q;
    assign rel_timeout    = rel_to_q;
    assign rel_burst      = rel_burst_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a cycle-level reference model of the
// grant rules compared on every clock, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MB  = 16;
    localparam int ITO = 32;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       busy;
    logic [1:0] grant_id;
    logic       rel_timeout;
    logic       rel_burst;

    uart_tx_arbiter_if #(.N_REQ(N), .BIT(W)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .BIT(W), .MAX_BURST(MB), .IDLE_TO(ITO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy), .grant_id(grant_id),
        .rel_timeout(rel_timeout), .rel_burst(rel_burst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Each requester is a queue of {last, byte} it wants to send, in order.
    logic [8:0] src_q [N][$];
    bit         gate [N];
    bit         full_r;

    // Reference model: owner (-1 = nobody), previous grantee, bytes in grant, quiet cycles.
    int m_owner, m_prev, m_sent, m_quiet;
    bit m_pto, m_pb;

    int log_id[$], log_dat[$], log_cyc[$], to_cyc[$], bu_cyc[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_owner = -1; m_prev = N - 1; m_sent = 0; m_quiet = 0; m_pto = 0; m_pb = 0;
    endtask

    task automatic clear_logs();
        log_id.delete(); log_dat.delete(); log_cyc.delete(); to_cyc.delete(); bu_cyc.delete();
    endtask

    // Present queue heads; lanes that are not valid carry junk data and junk last flags.
    task automatic drive();
        logic [N-1:0]   v, l;
        logic [N*W-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (gate[i] && src_q[i].size() > 0) begin
                v[i]       = 1'b1;
                d[i*W +: W] = src_q[i][0][7:0];
                l[i]       = src_q[i][0][8];
            end else begin
                d[i*W +: W] = 8'($urandom);
                l[i]       = 1'($urandom);
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.fifo_full = full_r;
    endtask

    task automatic push_msg(input int r, input logic [7:0] base, input int len, input bit with_last);
        for (int n = 0; n < len; n++) begin
            src_q[r].push_back({with_last && (n == len - 1), 8'(base + 8'(n))});
        end
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    // One clock: compare at negedge, advance sources and model, redrive after posedge.
    task automatic step();
        logic [N-1:0] v, l, exp_rdy;
        int  exp_gid, exp_dat, g, c;
        bit  exp_wr, found;
        @(negedge clk);
        v = bus.req_valid;
        l = bus.req_last;
        exp_gid = (m_owner >= 0) ? m_owner : m_prev;
        exp_rdy = '0; exp_wr = 0; exp_dat = 0;
        if (m_owner >= 0) begin
            exp_rdy[m_owner] = !full_r;
            exp_wr = v[m_owner] && !full_r;
            if (exp_wr) exp_dat = int'(src_q[m_owner][0][7:0]);
        end
        chk("busy", int'(busy), int'(m_owner >= 0));
        chk("grant_id", int'(grant_id), exp_gid);
        chk("rel_timeout", int'(rel_timeout), int'(m_pto));
        chk("rel_burst", int'(rel_burst), int'(m_pb));
        chk("req_ready", int'(bus.req_ready), int'(exp_rdy));
        chk("fifo_wr_en", int'(bus.fifo_wr_en), int'(exp_wr));
        chk("fifo_data", int'(bus.fifo_data), exp_dat);
        if (bus.fifo_wr_en) begin
            log_id.push_back(int'(grant_id)); log_dat.push_back(int'(bus.fifo_data)); log_cyc.push_back(cyc);
        end
        if (rel_timeout) to_cyc.push_back(cyc);
        if (rel_burst)   bu_cyc.push_back(cyc);
        for (int i = 0; i < N; i++) if (bus.req_valid[i] && bus.req_ready[i]) void'(src_q[i].pop_front());
        m_pto = 0; m_pb = 0;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_prev + k) % N;
                if (!found && v[c]) begin found = 1; m_owner = c; end
            end
            m_sent = 0; m_quiet = 0;
        end else begin
            g = m_owner;
            if (exp_wr) begin
                m_sent++; m_quiet = 0;
                if (l[g])             begin m_prev = g; m_owner = -1; end
                else if (m_sent == MB) begin m_prev = g; m_owner = -1; m_pb = 1; end
            end else if (!v[g]) begin
                m_quiet++;
                if (m_quiet == ITO) begin m_prev = g; m_owner = -1; m_pto = 1; end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_until_empty(input int budget);
        int b = 0;
        while (!all_empty() && b < budget) begin step(); b++; end
        chk("drain_within_budget", int'(all_empty()), 1);
        run(3);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin src_q[i].delete(); gate[i] = 0; end
        full_r = 0;
        drive();
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant_id", int'(grant_id), N - 1);
        chk("rst_wr_en", int'(bus.fifo_wr_en), 0);
        chk("rst_ready", int'(bus.req_ready), 0);
        chk("rst_pulses", int'({rel_timeout, rel_burst}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_reset();
        clear_logs();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, b;
        reset_n = 1'b1;
        full_r  = 0;
        for (int i = 0; i < N; i++) gate[i] = 0;
        m_reset();
        drive();
        #1;
        do_reset();

        // Single 3-byte message from requester 0.
        push_msg(0, 8'hA1, 3, 1); gate[0] = 1; drive();
        k = cyc;
        run_until_empty(20);
        chk("t1_count", log_dat.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_data", log_dat[i], 'hA1 + i);
            chk("t1_cycle", log_cyc[i], k + 1 + i);
            chk("t1_id", log_id[i], 0);
        end
        chk("t1_pulses", to_cyc.size() + bu_cyc.size(), 0);
        chk("t1_busy_after", int'(busy), 0);

        // Four requesters, 1-byte messages: 0,1,2,3,0,... every second cycle.
        do_reset();
        for (int n = 0; n < 2; n++) for (int i = 0; i < N; i++) push_msg(i, 8'(i * 16 + n), 1, 1);
        for (int i = 0; i < N; i++) gate[i] = 1;
        drive();
        run_until_empty(40);
        chk("t2_count", log_id.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", log_id[i], i % 4);
            chk("t2_data", log_dat[i], (i % 4) * 16 + i / 4);
            if (i > 0) chk("t2_spacing", log_cyc[i] - log_cyc[i-1], 2);
        end

        // Burst cap: requester 2 sends 20 bytes, requester 1 waits.
        do_reset();
        push_msg(2, 8'h00, 16, 0); push_msg(2, 8'h10, 4, 1); gate[2] = 1; drive();
        step();
        push_msg(1, 8'h80, 2, 1); gate[1] = 1; drive();
        run_until_empty(100);
        chk("t3_count", log_id.size(), 22);
        for (int i = 0; i < 22; i++) begin
            chk("t3_id", log_id[i], (i >= 16 && i < 18) ? 1 : 2);
            chk("t3_data", log_dat[i], (i < 16) ? i : (i < 18) ? ('h80 + i - 16) : ('h10 + i - 18));
        end
        chk("t3_burst_pulses", bu_cyc.size(), 1);
        if (bu_cyc.size() > 0) chk("t3_burst_cycle", bu_cyc[0], log_cyc[15] + 1);
        chk("t3_bubble1", log_cyc[16] - log_cyc[15], 2);
        chk("t3_bubble2", log_cyc[18] - log_cyc[17], 2);

        // Idle timeout, then a long full-FIFO stall that must not time out.
        do_reset();
        push_msg(1, 8'h11, 2, 0); gate[1] = 1; drive();
        run(45);
        chk("t4_count", log_id.size(), 2);
        chk("t4_to_pulses", to_cyc.size(), 1);
        // 32 quiet cycles inside the grant; the pulse shows in the cycle after the release edge.
        if (to_cyc.size() > 0) chk("t4_to_cycle", to_cyc[0] - log_cyc[1], ITO + 1);
        chk("t4_busy_after", int'(busy), 0);
        full_r = 1; push_msg(1, 8'h21, 3, 1); drive();
        run(100);
        chk("t4_stall_writes", log_id.size(), 2);
        chk("t4_stall_no_to", to_cyc.size(), 1);
        chk("t4_stall_busy", int'(busy), 1);
        full_r = 0; drive();
        run_until_empty(20);
        chk("t4_flow_count", log_id.size(), 5);
        for (int i = 2; i < 5 && i < log_dat.size(); i++) chk("t4_flow_data", log_dat[i], 'h21 + i - 2);

        // Asynchronous reset in the middle of requester 3's burst.
        do_reset();
        push_msg(3, 8'h30, 10, 1); gate[3] = 1; drive();
        b = 0;
        while (log_id.size() < 4 && b < 20) begin step(); b++; end
        chk("t5_reached_4", log_id.size(), 4);
        #1;
        chk("t5_pre_wr", int'(bus.fifo_wr_en), 1);
        chk("t5_pre_data", int'(bus.fifo_data), 'h34);
        reset_n = 1'b0;
        #1;
        chk("t5_async_wr", int'(bus.fifo_wr_en), 0);
        chk("t5_async_ready", int'(bus.req_ready), 0);
        chk("t5_async_busy", int'(busy), 0);
        do_reset();
        push_msg(0, 8'h40, 1, 1); push_msg(3, 8'h50, 1, 1); gate[0] = 1; gate[3] = 1; drive();
        run_until_empty(20);
        chk("t5_count", log_id.size(), 2);
        if (log_id.size() == 2) begin
            chk("t5_first", log_id[0], 0);
            chk("t5_second", log_id[1], 3);
        end

        // Burst cap and last on the same byte: plain release.
        do_reset();
        push_msg(0, 8'hC0, 16, 1); gate[0] = 1; drive();
        step();
        push_msg(1, 8'hD0, 1, 1); gate[1] = 1; drive();
        run_until_empty(60);
        chk("t6_count", log_id.size(), 17);
        chk("t6_no_burst_pulse", bu_cyc.size(), 0);
        if (log_id.size() == 17) begin
            chk("t6_id15", log_id[15], 0);
            chk("t6_id16", log_id[16], 1);
            chk("t6_data16", log_dat[16], 'hD0);
            chk("t6_bubble", log_cyc[16] - log_cyc[15], 2);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int t = 0; t < 4000; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                int r = $urandom_range(0, N - 1);
                if (src_q[r].size() < 40) push_msg(r, 8'($urandom), $urandom_range(1, 24), $urandom_range(0, 4) != 0);
            end
            for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) gate[i] = !gate[i];
            full_r = ($urandom_range(0, 3) == 0);
            drive();
            step();
        end
        for (int i = 0; i < N; i++) gate[i] = 1;
        full_r = 0;
        drive();
        run_until_empty(4000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
